// File: rtl/obi_req_buffer.sv
// obi_req_buffer
//   OBI request-channel buffer. A DEPTH-entry circular FIFO decouples the
//   upstream req/gnt handshake from the downstream one. It has optional
//   same-cycle fall-through when empty, a synchronous flush, and occupancy
//   status outputs.
//
// Ports
//   clk_i, rst_ni              clock, synchronous active-low reset
//   flush_i                    drop all stored entries at the next edge
//   s_req_i/s_we_i/s_be_i/
//   s_addr_i/s_wdata_i         upstream request
//   s_gnt_o                    upstream grant (registered state + flush_i only)
//   m_req_o/m_we_o/m_be_o/
//   m_addr_o/m_wdata_o         downstream request (head entry, or s_* on bypass)
//   m_gnt_i                    downstream grant
//   count_o, full_o, empty_o   occupancy
module obi_req_buffer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter bit FALL_THROUGH = 1'b0,
  localparam int BE_WIDTH    = DATA_WIDTH / 8,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  s_req_i,
  input  logic                  s_we_i,
  input  logic [BE_WIDTH-1:0]   s_be_i,
  input  logic [ADDR_WIDTH-1:0] s_addr_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  output logic                  s_gnt_o,
  output logic                  m_req_o,
  output logic                  m_we_o,
  output logic [BE_WIDTH-1:0]   m_be_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  input  logic                  m_gnt_i,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          s_ent, head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          bypass, push, pop;

  assign s_ent   = '{we: s_we_i, be: s_be_i, addr: s_addr_i, wdata: s_wdata_i};
  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;

  // Grant is a function of stored occupancy and flush only, so downstream
  // back-pressure never reaches the upstream grant combinationally.
  assign s_gnt_o = !full_o && !flush_i;

  // Fall-through path: only when nothing is stored, so ordering is preserved.
  assign bypass = FALL_THROUGH && empty_o;

  always_comb begin
    head    = mem[rptr];
    m_req_o = !empty_o;
    if (bypass) begin
      head    = s_ent;
      // A flushed upstream request is not granted, so it must not go out.
      m_req_o = s_req_i && !flush_i;
    end
  end

  assign m_we_o    = head.we;
  assign m_be_o    = head.be;
  assign m_addr_o  = head.addr;
  assign m_wdata_o = head.wdata;

  // A bypassed request that is granted downstream is never stored.
  assign push = s_req_i && s_gnt_o && !(bypass && m_gnt_i);
  assign pop  = !empty_o && m_gnt_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; its contents are only visible through count.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= s_ent;
  end

endmodule
